hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Generates the Stall input consumed by the ID-stage control unit, plus front-end write enables.
//  Detects load-use hazards (1-cycle bubble) and sequences multi-cycle DIV/DIVU/REM/REMU occupancy of EX.
//  Sits between IF/ID and ID/EX. Drives the PC register, the IF/ID register, the control unit and the ID/EX/EX hold logic.
// PARAMETERS
//  MDIV_CYCLES  default 4  cycles a DIV-class op occupies EX; legal range >=1; 1 => no divider stall
// PORTS
//  CLK                 in   1   pipeline clock; all state on rising edge
//  RESET               in   1   synchronous, active-high
//  if_id_instruction   in   32  instruction currently in ID
//  id_ex_mem_read      in   1   instruction in EX is a load
//  id_ex_rd            in   5   destination register of instruction in EX
//  id_ex_AlU_opcode    in   5   ALU opcode of instruction in EX
//  flush               in   1   taken branch/jump squashes the ID instruction this cycle
//  Stall               out  1   to control unit: force NOP control word (bubble into ID/EX)
//  pc_write_enable     out  1   0 = hold PC
//  if_id_write_enable  out  1   0 = hold IF/ID
//  ex_hold             out  1   1 = hold ID/EX register and EX-stage operands
//  mdiv_busy           out  1   FSM in BUSY state (registered)
// BEHAVIOUR
//  - Fields: rs1=[19:15], rs2=[24:20], op=[6:0]. rs1_used: op not LUI 0110111, AUIPC 0010111 or JAL 1101111.
//    rs2_used: op in {0110011 R, 0100011 store, 1100011 branch}.
//  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)) & ~flush.
//  - is_mdiv = id_ex_AlU_opcode in {01000 DIV, 01001 DIVU, 01010 REM, 01011 REMU}.
//  - FSM states: IDLE, BUSY. Down-counter cnt has width clog2(MDIV_CYCLES), minimum 1.
//    IDLE & is_mdiv & MDIV_CYCLES>1: ex_hold=1 this cycle. Next state is BUSY, with cnt<=MDIV_CYCLES-2.
//    BUSY & cnt!=0: ex_hold=1; cnt<=cnt-1.
//    BUSY & cnt==0: ex_hold=0, so the op leaves EX at this edge. Next state is IDLE.
//    => a DIV-class op spends exactly MDIV_CYCLES cycles in EX, with MDIV_CYCLES-1 hold cycles.
//  - Outputs are combinational (Mealy) from state, cnt and inputs:
//    ex_hold=1:       pc_write_enable=0, if_id_write_enable=0, Stall=0 (ID/EX frozen, no bubble).
//    else load_use=1: Stall=1, pc_write_enable=0, if_id_write_enable=0 for one cycle.
//                     The load then moves to MEM and the hazard clears naturally. No state is needed.
//    else:            Stall=0, pc_write_enable=1, if_id_write_enable=1.
//  - Priority: divider hold > load-use. In the BUSY cnt==0 release cycle, load-use is evaluated normally.
//  - is_mdiv is ignored while in BUSY, so the held op cannot retrigger. A back-to-back DIV entering EX
//    the cycle after release starts a fresh sequence from IDLE.
//  - flush suppresses load_use only. flush cannot coincide with BUSY because DIV is not a branch.
//  - Reset: while RESET=1, outputs are forced to Stall=0, pc_write_enable=1, if_id_write_enable=1,
//    ex_hold=0, mdiv_busy=0. At the edge: state<=IDLE, cnt<=0.
//    RESET during BUSY abandons the sequence. The first cycle after reset is IDLE.
//  - mdiv_busy = (state==BUSY); reset value 0.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds two outputs.
//    load_use_count [31:0]: +1 each cycle load_use causes Stall=1.
//    mdiv_stall_count [31:0]: +1 each cycle ex_hold=1.
//    Both reset to 0, wrap modulo 2^32 with no saturation, and are not incremented during RESET.
//  HAZ_PERF_CNT_EN undefined: counter ports and logic are absent, and all other behaviour is identical.
// TESTING
//  1 EX: lw x5 (mem_read=1, rd=5); ID: add x6,x5,x7
//    -> Stall=1, pc_we=0, if_id_we=0 for 1 cycle; next cycle (EX=bubble) all released.
//  2 EX: lw x0; ID: add x6,x0,x0 -> no stall.
//    EX: lw x5; ID: lui x5 -> no stall.
//    EX: lw x5; ID: sw x5,0(x1) (rs2=5) -> Stall=1.
//  3 MDIV_CYCLES=4, DIV (01000) enters EX -> ex_hold=1 for 3 cycles, mdiv_busy=1 for 3 cycles
//    (cycles 2-4), op leaves after cycle 4. MDIV_CYCLES=1 -> no hold.
//  4 DIV in EX plus load-use pattern in ID -> ex_hold=1 and Stall=0 during hold; Stall=1 exactly in the release cycle.
//  5 RESET asserted in 2nd BUSY cycle -> outputs idle same cycle; after release, with no DIV in EX,
//    mdiv_busy=0 and ex_hold=0.
//    EX: lw x5; ID: add x6,x5,x7 with flush=1 -> Stall=0.
//  6 HAZ_PERF_CNT_EN: run scenarios 1 and 3 -> load_use_count=1, mdiv_stall_count=3.
//    Preload near wrap via force -> 0xFFFFFFFF+1=0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall unit bundle: ID-stage instruction, EX-stage load/ALU info, flush,
// and the stall/enable/hold controls fed back to the front end.
// Optional perf counters appear when HAZ_PERF_CNT_EN is defined.
interface hazard_stall_unit_if;
   logic [31:0] if_id_instruction;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rd;
   logic [4:0]  id_ex_AlU_opcode;
   logic        flush;
   logic        Stall;
   logic        pc_write_enable;
   logic        if_id_write_enable;
   logic        ex_hold;
   logic        mdiv_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] load_use_count;
   logic [31:0] mdiv_stall_count;
`endif

   // pipeline side: supplies instruction/EX info, consumes controls
   modport master (
      output if_id_instruction, id_ex_mem_read, id_ex_rd, id_ex_AlU_opcode, flush,
`ifdef HAZ_PERF_CNT_EN
      input  load_use_count, mdiv_stall_count,
`endif
      input  Stall, pc_write_enable, if_id_write_enable, ex_hold, mdiv_busy
   );

   // hazard unit side
   modport slave (
      input  if_id_instruction, id_ex_mem_read, id_ex_rd, id_ex_AlU_opcode, flush,
`ifdef HAZ_PERF_CNT_EN
      output load_use_count, mdiv_stall_count,
`endif
      output Stall, pc_write_enable, if_id_write_enable, ex_hold, mdiv_busy
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use bubble detection plus multi-cycle DIV/REM occupancy sequencing of EX.
// Divider hold takes priority over the load-use bubble; outputs are Mealy.
// Optional feature macro: HAZ_PERF_CNT_EN adds load-use / divider-hold cycle counters.
module hazard_stall_unit #(
   parameter int MDIV_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   hazard_stall_unit_if.slave hz
);
   localparam int          CW         = (MDIV_CYCLES > 2) ? $clog2(MDIV_CYCLES) : 1;
   localparam int          CNT_LOAD_I = (MDIV_CYCLES > 1) ? MDIV_CYCLES - 2 : 0;
   localparam logic [CW-1:0] CNT_LOAD = CNT_LOAD_I[CW-1:0];
   localparam bit          MDIV_EN    = (MDIV_CYCLES > 1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [4:0] rs1, rs2;
   logic [6:0] op;
   logic       rs1_used, rs2_used, load_use, is_mdiv, hold;
   logic       unused_instr_bits;

   assign rs1 = hz.if_id_instruction[19:15];
   assign rs2 = hz.if_id_instruction[24:20];
   assign op  = hz.if_id_instruction[6:0];
   assign unused_instr_bits = ^{hz.if_id_instruction[31:25], hz.if_id_instruction[14:7]};

   assign rs1_used = (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
   assign rs2_used = (op == OP_R) || (op == OP_ST) || (op == OP_BR);

   // a squashed ID instruction never needs a bubble
   assign load_use = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                     ((rs1_used && (hz.id_ex_rd == rs1)) || (rs2_used && (hz.id_ex_rd == rs2))) &&
                     !hz.flush;

   // DIV, DIVU, REM, REMU occupy 01000..01011
   assign is_mdiv = (hz.id_ex_AlU_opcode[4:2] == 3'b010);

   // state and down-counter register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state and EX hold; is_mdiv ignored in BUSY so the held op cannot retrigger
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold    = 1'b0;
      case (state_q)
         IDLE: if (is_mdiv && MDIV_EN) begin
            hold    = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
         end
         BUSY: if (cnt_q != '0) begin
            hold  = 1'b1;
            cnt_d = cnt_q - 1'b1;
         end else begin
            state_d = IDLE;
         end
      endcase
   end

   // front-end controls; reset forces the pipeline to run freely
   always_comb begin
      hz.Stall              = 1'b0;
      hz.pc_write_enable    = 1'b1;
      hz.if_id_write_enable = 1'b1;
      hz.ex_hold            = 1'b0;
      hz.mdiv_busy          = 1'b0;
      if (!RESET) begin
         hz.mdiv_busy = (state_q == BUSY);
         if (hold) begin
            hz.ex_hold            = 1'b1;
            hz.pc_write_enable    = 1'b0;
            hz.if_id_write_enable = 1'b0;
         end else if (load_use) begin
            hz.Stall              = 1'b1;
            hz.pc_write_enable    = 1'b0;
            hz.if_id_write_enable = 1'b0;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] lu_cnt_q, mdiv_cnt_q;

   // cycle counters, free-running modulo 2^32
   always_ff @(posedge CLK) begin
      if (RESET) begin
         lu_cnt_q   <= '0;
         mdiv_cnt_q <= '0;
      end else begin
         if (hz.Stall)   lu_cnt_q   <= lu_cnt_q + 32'd1;
         if (hz.ex_hold) mdiv_cnt_q <= mdiv_cnt_q + 32'd1;
      end
   end

   assign hz.load_use_count   = lu_cnt_q;
   assign hz.mdiv_stall_count = mdiv_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use cases, divider sequencing,
// priority, reset abort, flush, and (with HAZ_PERF_CNT_EN) the perf counters.
module tb_hazard_stall_unit;
   logic CLK = 1'b0;
   logic RESET;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 CLK = ~CLK;

   hazard_stall_unit_if hif ();
   hazard_stall_unit_if hif1 ();

   hazard_stall_unit #(.MDIV_CYCLES(4)) dut  (.CLK(CLK), .RESET(RESET), .hz(hif.slave));
   hazard_stall_unit #(.MDIV_CYCLES(1)) dut1 (.CLK(CLK), .RESET(RESET), .hz(hif1.slave));

   localparam logic [6:0] R_OP  = 7'b0110011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] OPIMM = 7'b0010011;
   localparam logic [4:0] ADD   = 5'b00000;
   localparam logic [4:0] DIV   = 5'b01000;
   localparam logic [4:0] REMU  = 5'b01011;
   localparam logic [4:0] NOMD  = 5'b01100;

   function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] op);
      return {7'd0, rs2, rs1, 3'd0, 5'd6, op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] aluop,
                      input logic [31:0] ins, input logic fl);
      hif.id_ex_mem_read    = mr;
      hif.id_ex_rd          = rd;
      hif.id_ex_AlU_opcode  = aluop;
      hif.if_id_instruction = ins;
      hif.flush             = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // {Stall, pc_we, if_id_we, ex_hold, mdiv_busy}
   function automatic logic [4:0] outs();
      return {hif.Stall, hif.pc_write_enable, hif.if_id_write_enable, hif.ex_hold, hif.mdiv_busy};
   endfunction

   initial begin
      hif1.id_ex_mem_read = 1'b0; hif1.id_ex_rd = 5'd0; hif1.id_ex_AlU_opcode = ADD;
      hif1.if_id_instruction = 32'h0000_0013; hif1.flush = 1'b0;

      // reset with a load-use and a DIV present: outputs must still be idle
      RESET = 1'b1;
      drv(1'b1, 5'd5, DIV, mk(5'd5, 5'd7, R_OP), 1'b0);
      chk("reset_outs", outs(), 5'b01100);
      tick();
      chk("reset_outs2", outs(), 5'b01100);
      tick();
      RESET = 1'b0;

      // 1: lw x5 ; add x6,x5,x7 -> one bubble
      drv(1'b1, 5'd5, ADD, mk(5'd5, 5'd7, R_OP), 1'b0);
      chk("lu_rs1", outs(), 5'b10000);
      tick();
      drv(1'b0, 5'd0, ADD, mk(5'd5, 5'd7, R_OP), 1'b0);
      chk("lu_release", outs(), 5'b01100);
      tick();

      // 2: x0 destination, unused fields, store rs2, rs2 on I-type
      drv(1'b1, 5'd0, ADD, mk(5'd0, 5'd0, R_OP), 1'b0);
      chk("lu_x0", outs(), 5'b01100);
      drv(1'b1, 5'd5, ADD, mk(5'd5, 5'd5, LUI), 1'b0);
      chk("lu_lui", outs(), 5'b01100);
      drv(1'b1, 5'd5, ADD, mk(5'd1, 5'd5, STORE), 1'b0);
      chk("lu_store_rs2", outs(), 5'b10000);
      drv(1'b1, 5'd5, ADD, mk(5'd1, 5'd5, OPIMM), 1'b0);
      chk("lu_imm_rs2", outs(), 5'b01100);
      drv(1'b0, 5'd5, ADD, mk(5'd5, 5'd7, R_OP), 1'b0);
      chk("lu_noload", outs(), 5'b01100);
      tick();

      // 3: DIV with MDIV_CYCLES=4, and MDIV_CYCLES=1 instance
      hif1.id_ex_AlU_opcode = DIV;
      drv(1'b0, 5'd0, DIV, 32'h0000_0013, 1'b0);
      chk("div_c1", outs(), 5'b00010);
      chk("div1_c1", {hif1.ex_hold, hif1.mdiv_busy, hif1.pc_write_enable}, 3'b001);
      tick();
      chk("div_c2", outs(), 5'b00011);
      chk("div1_c2", {hif1.ex_hold, hif1.mdiv_busy, hif1.pc_write_enable}, 3'b001);
      tick();
      hif1.id_ex_AlU_opcode = ADD;
      chk("div_c3", outs(), 5'b00011);
      tick();
      chk("div_c4_release", outs(), 5'b01101);
      tick();
      // back-to-back REMU starts fresh
      drv(1'b0, 5'd0, REMU, 32'h0000_0013, 1'b0);
      chk("remu_c1", outs(), 5'b00010);
      tick(); tick(); tick();
      chk("remu_c4_release", outs(), 5'b01101);
      tick();
      drv(1'b0, 5'd0, NOMD, 32'h0000_0013, 1'b0);
      chk("nonmdiv_op", outs(), 5'b01100);
      tick();

      // 4: DIV hold beats load-use; bubble lands in the release cycle
      drv(1'b1, 5'd5, DIV, mk(5'd5, 5'd7, R_OP), 1'b0);
      chk("prio_c1", outs(), 5'b00010);
      tick();
      chk("prio_c2", outs(), 5'b00011);
      tick();
      chk("prio_c3", outs(), 5'b00011);
      tick();
      chk("prio_c4", outs(), 5'b10001);
      tick();
      drv(1'b0, 5'd0, ADD, 32'h0000_0013, 1'b0);
      chk("prio_after", outs(), 5'b01100);
      tick();

      // 5: reset in the second BUSY cycle
      drv(1'b0, 5'd0, DIV, 32'h0000_0013, 1'b0);
      tick();
      tick();
      RESET = 1'b1;
      #1;
      chk("rst_busy_same", outs(), 5'b01100);
      tick();
      RESET = 1'b0;
      drv(1'b0, 5'd0, ADD, 32'h0000_0013, 1'b0);
      chk("rst_busy_after", outs(), 5'b01100);
      tick();
      chk("rst_busy_after2", outs(), 5'b01100);
      // flush suppresses load-use
      drv(1'b1, 5'd5, ADD, mk(5'd5, 5'd7, R_OP), 1'b1);
      chk("flush", outs(), 5'b01100);
      tick();

`ifdef HAZ_PERF_CNT_EN
      // 6: counters over scenario 1 plus one DIV sequence
      RESET = 1'b1;
      drv(1'b0, 5'd0, ADD, 32'h0000_0013, 1'b0);
      tick();
      RESET = 1'b0;
      chk("cnt_reset_lu", hif.load_use_count, 32'd0);
      drv(1'b1, 5'd5, ADD, mk(5'd5, 5'd7, R_OP), 1'b0);
      tick();
      drv(1'b0, 5'd0, ADD, mk(5'd5, 5'd7, R_OP), 1'b0);
      tick();
      drv(1'b0, 5'd0, DIV, 32'h0000_0013, 1'b0);
      tick(); tick(); tick(); tick();
      drv(1'b0, 5'd0, ADD, 32'h0000_0013, 1'b0);
      chk("cnt_lu", hif.load_use_count, 32'd1);
      chk("cnt_mdiv", hif.mdiv_stall_count, 32'd3);
      force dut.mdiv_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.mdiv_cnt_q;
      drv(1'b0, 5'd0, DIV, 32'h0000_0013, 1'b0);
      tick();
      chk("cnt_wrap", hif.mdiv_stall_count, 32'd0);
      tick(); tick(); tick();
      drv(1'b0, 5'd0, ADD, 32'h0000_0013, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
